// File: rtl/step_gen_pkg.sv
// Shared definitions for the step-enable generator: debounce FSM encoding and
// the width of the issued-step counter.
package step_gen_pkg;

  localparam logic [1:0] LO   = 2'd0;
  localparam logic [1:0] RISE = 2'd1;
  localparam logic [1:0] HI   = 2'd2;
  localparam logic [1:0] FALL = 2'd3;

  localparam int STEP_CNT_W = 16;

  // The debounced level is high while the FSM believes the input is high,
  // including while a candidate low is still being qualified.
  function automatic logic state_is_high(input logic [1:0] st);
    return (st == HI) || (st == FALL);
  endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchronizer plus four-state debounce FSM. `level` is the registered
// debounced level; `rise` strobes in the cycle whose edge commits a low-to-high.
module sync_debounce
  import step_gen_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic             s1_q;
  logic             s2_q;
  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             level_d;
  logic             rise_d;

  // Next-state logic; the counter restarts on every state change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = 1'b0;
    case (state_q)
      LO: begin
        if (s2_q) begin
          state_d = RISE;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end
      RISE: begin
        if (!s2_q) begin
          state_d = LO;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HI;
          cnt_d   = CNT_ZERO;
          rise_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      HI: begin
        if (!s2_q) begin
          state_d = FALL;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end
      FALL: begin
        if (s2_q) begin
          state_d = HI;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
          state_d = LO;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = LO;
        cnt_d   = CNT_ZERO;
      end
    endcase
    level_d = state_is_high(state_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= LO;
      cnt_q   <= CNT_ZERO;
      level_q <= 1'b0;
    end else begin
      s1_q    <= din;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_d;

endmodule

// File: rtl/step_gen.sv
// Step-enable generator: debounced button steps, optional periodic auto-run
// (enabled by defining STEP_GEN_AUTORUN_EN), and a wrapping issued-step count.
module step_gen
  import step_gen_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned RUN_DIV         = 25000000,
  parameter int unsigned CNT_W           = 32
) (
  input  logic                  gclk,
  input  logic                  rst,
  input  logic                  btn,
  input  logic                  run,
  output logic                  step,
  output logic                  btn_level,
  output logic [STEP_CNT_W-1:0] step_cnt
);

  logic                  btn_level_s;
  logic                  rise_s;
  logic                  manual_s;
  logic                  auto_s;
  logic                  step_q;
  logic                  step_d;
  logic [STEP_CNT_W-1:0] step_cnt_q;
  logic [STEP_CNT_W-1:0] step_cnt_d;

  sync_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_btn (
    .clk   (gclk),
    .rst   (rst),
    .din   (btn),
    .level (btn_level_s),
    .rise  (rise_s)
  );

`ifdef STEP_GEN_AUTORUN_EN
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(RUN_DIV - 1);
  localparam logic [CNT_W-1:0] DIV_ZERO = {CNT_W{1'b0}};

  logic             run_s1_q;
  logic             run_s2_q;
  logic [CNT_W-1:0] div_q;
  logic [CNT_W-1:0] div_d;

  // Divider parks at zero while the run switch is off, so the first auto
  // step lands a full period after the switch is seen on.
  always_comb begin
    div_d = div_q;
    if (!run_s2_q) begin
      div_d = DIV_ZERO;
    end else if (div_q == DIV_LAST) begin
      div_d = DIV_ZERO;
    end else begin
      div_d = div_q + CNT_W'(1);
    end
  end

  always_ff @(posedge gclk) begin
    if (rst) begin
      run_s1_q <= 1'b0;
      run_s2_q <= 1'b0;
      div_q    <= DIV_ZERO;
    end else begin
      run_s1_q <= run;
      run_s2_q <= run_s1_q;
      div_q    <= div_d;
    end
  end

  assign manual_s = ~run_s2_q;
  assign auto_s   = run_s2_q & (div_q == DIV_LAST);
`else
  localparam int unsigned unused_run_div = RUN_DIV;
  logic unused_run_s;

  assign unused_run_s = run;
  assign manual_s     = 1'b1;
  assign auto_s       = 1'b0;
`endif

  // Manual and auto steps are mutually exclusive through run_s, and each
  // source alone can never fire on back-to-back cycles.
  always_comb begin
    step_d = (manual_s & rise_s) | auto_s;
    if (step_d) begin
      step_cnt_d = step_cnt_q + STEP_CNT_W'(1);
    end else begin
      step_cnt_d = step_cnt_q;
    end
  end

  always_ff @(posedge gclk) begin
    if (rst) begin
      step_q     <= 1'b0;
      step_cnt_q <= {STEP_CNT_W{1'b0}};
    end else begin
      step_q     <= step_d;
      step_cnt_q <= step_cnt_d;
    end
  end

  assign step      = step_q;
  assign btn_level = btn_level_s;
  assign step_cnt  = step_cnt_q;

endmodule

// File: tb/tb_step_gen.sv
// Randomized and directed bench for step_gen against a streak-counting model
// of the debounce/auto-run rules.
module tb_step_gen;

  localparam int DEB  = 4;
  localparam int RDIV = 5;
`ifdef STEP_GEN_AUTORUN_EN
  localparam bit AUTORUN = 1'b1;
`else
  localparam bit AUTORUN = 1'b0;
`endif

  logic        gclk = 1'b0;
  logic        rst  = 1'b1;
  logic        btn  = 1'b0;
  logic        run  = 1'b0;
  logic        step;
  logic        btn_level;
  logic [15:0] step_cnt;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model state
  logic        m_b1, m_b2, m_r1, m_r2;
  logic        m_level, m_step;
  int          m_streak, m_run_age;
  logic [15:0] m_cnt;
  logic        prev_step = 1'b0;

  step_gen #(
    .DEBOUNCE_CYCLES (DEB),
    .RUN_DIV         (RDIV),
    .CNT_W           (32)
  ) dut (
    .gclk      (gclk),
    .rst       (rst),
    .btn       (btn),
    .run       (run),
    .step      (step),
    .btn_level (btn_level),
    .step_cnt  (step_cnt)
  );

  always #5 gclk = ~gclk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge of the rules: level flips once the synchronized input has
  // disagreed with it on DEB+1 consecutive edges; auto steps every RDIV edges.
  task automatic model_edge(input logic b, input logic r, input logic rs);
    logic commit;
    logic fire;
    if (rs) begin
      m_b1 = 1'b0; m_b2 = 1'b0; m_r1 = 1'b0; m_r2 = 1'b0;
      m_level = 1'b0; m_step = 1'b0; m_streak = 0; m_run_age = 0;
      m_cnt = 16'd0;
    end else begin
      commit = 1'b0;
      fire   = 1'b0;
      if (m_b2 != m_level) begin
        m_streak++;
        if (m_streak == DEB + 1) begin
          m_level  = ~m_level;
          commit   = m_level;
          m_streak = 0;
        end
      end else begin
        m_streak = 0;
      end
      if (AUTORUN && m_r2) begin
        m_run_age++;
        fire = ((m_run_age % RDIV) == 0);
        m_step = fire;
      end else begin
        m_run_age = 0;
        m_step = commit;
      end
      m_cnt = m_cnt + 16'(m_step);
      m_b2 = m_b1; m_b1 = b;
      m_r2 = m_r1; m_r1 = r;
    end
  endtask

  task automatic cyc(input logic b, input logic r, input logic rs);
    btn = b; run = r; rst = rs;
    @(posedge gclk);
    model_edge(b, r, rs);
    @(negedge gclk);
    check("step", int'(step), int'(m_step));
    check("level", int'(btn_level), int'(m_level));
    check("cnt", int'(step_cnt), int'(m_cnt));
    check("no_double", int'(step & prev_step), 0);
    prev_step = step;
  endtask

  initial begin
    int first_k;
    int pulses;
    logic bseq [7];
    logic tgt, bnc, rv, bv, rsv;
    int seg;

    // Reset
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1);
    check("rst_step", int'(step), 0);
    check("rst_level", int'(btn_level), 0);
    check("rst_cnt", int'(step_cnt), 0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0);

    // Clean press: step exactly DEB+2 edges after the first sampling edge
    first_k = -1; pulses = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(1'b1, 1'b0, 1'b0);
      if (step) begin
        pulses++;
        if (first_k < 0) first_k = k;
      end
    end
    check("press_lat", first_k, DEB + 2);
    check("press_pulses", pulses, 1);
    check("press_level", int'(btn_level), 1);
    check("press_cnt", int'(step_cnt), 1);
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      cyc(1'b0, 1'b0, 1'b0);
      if (step) pulses++;
    end
    check("release_pulses", pulses, 0);
    check("release_level", int'(btn_level), 0);

    // Bounce: the 0 restarts qualification; last rise sampled at k=3
    bseq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    first_k = -1; pulses = 0;
    for (int k = 0; k < 22; k++) begin
      cyc((k < 7) ? bseq[k] : 1'b1, 1'b0, 1'b0);
      if (step) begin
        pulses++;
        if (first_k < 0) first_k = k;
      end
    end
    check("bounce_lat", first_k, 3 + DEB + 2);
    check("bounce_pulses", pulses, 1);
    check("bounce_cnt", int'(step_cnt), 2);
    for (int k = 0; k < 15; k++) cyc(1'b0, 1'b0, 1'b0);

    // Auto-run for 30 cycles with a button press in the middle
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      cyc((k >= 8 && k < 20) ? 1'b1 : 1'b0, 1'b1, 1'b0);
      if (step) pulses++;
    end
    check("auto_pulses", pulses, AUTORUN ? 5 : 1);
    for (int k = 0; k < 20; k++) cyc(1'b0, 1'b0, 1'b0);

    // Reset while in RISE with the counter at 2
    for (int k = 0; k < 5; k++) cyc(1'b1, 1'b0, 1'b0);
    check("mid_level", int'(btn_level), 0);
    for (int k = 0; k < 2; k++) cyc(1'b1, 1'b0, 1'b1);
    check("midrst_step", int'(step), 0);
    check("midrst_level", int'(btn_level), 0);
    check("midrst_cnt", int'(step_cnt), 0);
    first_k = -1;
    for (int k = 0; k < 12; k++) begin
      cyc(1'b1, 1'b0, 1'b0);
      if (step && first_k < 0) first_k = k;
    end
    check("midrst_lat", first_k, DEB + 2);
    for (int k = 0; k < 15; k++) cyc(1'b0, 1'b0, 1'b0);

    // Counter wrap from 16'hFFFF
    force dut.step_cnt_q = 16'hFFFF;
    #1;
    release dut.step_cnt_q;
    m_cnt = 16'hFFFF;
    for (int k = 0; k < 12; k++) cyc(1'b1, 1'b0, 1'b0);
    check("wrap_cnt", int'(step_cnt), 0);
    for (int k = 0; k < 15; k++) cyc(1'b0, 1'b0, 1'b0);

    // Randomized: held segments, bouncy segments, run toggles, rare resets
    seg = 0; tgt = 1'b0; bnc = 1'b0; rv = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      if (seg == 0) begin
        tgt = 1'($urandom_range(0, 1));
        bnc = ($urandom_range(0, 3) == 0);
        seg = bnc ? int'($urandom_range(1, 6)) : int'($urandom_range(1, 16));
      end
      seg--;
      bv  = bnc ? 1'($urandom_range(0, 1)) : tgt;
      if ($urandom_range(0, 39) == 0) rv = ~rv;
      rsv = ($urandom_range(0, 299) == 0);
      cyc(bv, rv, rsv);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
